// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset CPU: opcodes, funct codes,
// datapath select encodings, FSM states and the decoder result payload.
package cpu_defs_pkg;

  localparam int unsigned ALU_W   = 3;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_JR  = 6'h08;
  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_XOR = 3'b010,
    ALU_SLT = 3'b011
  } alu_ctrl_e;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_RALU, CLS_ADDI, CLS_XORI, CLS_LW, CLS_SW,
    CLS_BNE, CLS_J, CLS_JAL, CLS_JR, CLS_ILL
  } instr_cls_e;

  typedef struct packed {
    instr_cls_e cls;
    alu_ctrl_e  alu;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder: instruction class, EXEC-cycle ALU operation
// and illegal-instruction flag.
module ctrl_decode
  import cpu_defs_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  output dec_t            dec_c
);

  always_comb begin
    dec_c.cls     = CLS_ILL;
    dec_c.alu     = ALU_ADD;
    dec_c.illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  dec_c.cls = CLS_RALU;
          FN_SUB:  begin dec_c.cls = CLS_RALU; dec_c.alu = ALU_SUB; end
          FN_SLT:  begin dec_c.cls = CLS_RALU; dec_c.alu = ALU_SLT; end
          FN_JR:   dec_c.cls = CLS_JR;
          default: dec_c.cls = CLS_ILL;
        endcase
      end
      OP_J:    dec_c.cls = CLS_J;
      OP_JAL:  dec_c.cls = CLS_JAL;
      OP_BNE:  begin dec_c.cls = CLS_BNE; dec_c.alu = ALU_SUB; end
      OP_ADDI: dec_c.cls = CLS_ADDI;
      OP_XORI: begin dec_c.cls = CLS_XORI; dec_c.alu = ALU_XOR; end
      OP_LW:   dec_c.cls = CLS_LW;
      OP_SW:   dec_c.cls = CLS_SW;
      default: dec_c.cls = CLS_ILL;
    endcase
    dec_c.illegal = (dec_c.cls == CLS_ILL);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM sequencing FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Optional PERF_CNT_EN adds cycle and retired-instruction counters.
module multicycle_controller
  import cpu_defs_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_wr,
  output logic               mem_src,
  output logic               ir_wr,
  output logic               pc_wr,
  output logic [1:0]         pc_src,
  output logic [ALU_W-1:0]   alu_ctrl,
  output logic               alu_src,
  output logic [1:0]         reg_dst,
  output logic               reg_wr,
  output logic [1:0]         mem_to_reg,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]        cyc_cnt,
  output logic [31:0]        instr_cnt
`endif
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   run_q, run_d;
  dec_t   dec;

  ctrl_decode u_dec (
    .opcode (opcode),
    .funct  (funct),
    .dec_c  (dec)
  );

  // run_q keeps FETCH quiet during reset and for the release edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      run_q     <= run_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    run_d      = 1'b1;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_src    = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = PC_PLUS4;
    alu_ctrl   = ALU_ADD;
    alu_src    = 1'b0;
    reg_dst    = RD_RT;
    reg_wr     = 1'b0;
    mem_to_reg = WD_ALU;
    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_wr   = 1'b1;
            pc_wr   = 1'b1;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (dec.illegal) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          case (dec.cls)
            CLS_J:   begin pc_wr = 1'b1; pc_src = PC_JUMP; state_d = S_FETCH; end
            CLS_JR:  begin pc_wr = 1'b1; pc_src = PC_RS;   state_d = S_FETCH; end
            CLS_JAL: begin
              pc_wr      = 1'b1;
              pc_src     = PC_JUMP;
              reg_wr     = 1'b1;
              reg_dst    = RD_RA;
              mem_to_reg = WD_PC4;
              state_d    = S_FETCH;
            end
            default: state_d = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        alu_ctrl = dec.alu;
        alu_src  = (dec.cls inside {CLS_ADDI, CLS_XORI, CLS_LW, CLS_SW});
        case (dec.cls)
          CLS_RALU, CLS_ADDI, CLS_XORI: state_d = S_WB;
          CLS_LW, CLS_SW:               state_d = S_MEM;
          CLS_BNE: begin
            pc_wr   = !alu_zero;
            pc_src  = PC_BRANCH;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_src = 1'b1;
        mem_wr  = (dec.cls == CLS_SW);
        if (mem_ready) state_d = (dec.cls == CLS_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_wr     = 1'b1;
        reg_dst    = (dec.cls == CLS_RALU) ? RD_RD : RD_RT;
        mem_to_reg = (dec.cls == CLS_LW) ? WD_MEM : WD_ALU;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  assign illegal   = illegal_q;
  assign dbg_state = state_q;

`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d, instr_cnt_q, instr_cnt_d;
  logic        retire_c;

  // an instruction retires whenever the FSM re-enters FETCH
  assign retire_c = (state_q != S_FETCH) && (state_d == S_FETCH);

  always_comb begin
    cyc_cnt_d   = cyc_cnt_q + 32'd1;
    instr_cnt_d = instr_cnt_q + 32'(retire_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q   <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      cyc_cnt_q   <= cyc_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cyc_cnt   = cyc_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through the FSM
// and compares every strobe per cycle; counter checks when PERF_CNT_EN is defined.
module tb_multicycle_controller;

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, H = 3'd5;

  logic       clk, rst_n, alu_zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       mem_req, mem_wr, mem_src, ir_wr, pc_wr, alu_src, reg_wr, illegal;
  logic [1:0] pc_src, reg_dst, mem_to_reg;
  logic [2:0] alu_ctrl, dbg_state;
  int         checks = 0;
  int         failures = 0;

`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt, instr_cnt, exp_cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) exp_cyc <= 32'd0;
    else        exp_cyc <= exp_cyc + 32'd1;
`endif

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_wr(mem_wr), .mem_src(mem_src),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
    .reg_dst(reg_dst), .reg_wr(reg_wr), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .dbg_state(dbg_state)
`ifdef PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] ev(input logic [2:0] st, input logic mreq, mwr, msrc, irw, pcw,
                                     input logic [1:0] pcs, input logic [2:0] aluc, input logic alus,
                                     input logic [1:0] rdst, input logic rw, input logic [1:0] m2r,
                                     input logic ill);
    return {mreq, mwr, msrc, irw, pcw, pcs, aluc, alus, rdst, rw, m2r, ill, st};
  endfunction

  function automatic logic [19:0] z(input logic [2:0] st);
    return ev(st, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 2'd0, 0, 2'd0, 0);
  endfunction

  task automatic chk(input string tag, input logic [19:0] exp);
    logic [19:0] obs;
    obs = {mem_req, mem_wr, mem_src, ir_wr, pc_wr, pc_src, alu_ctrl, alu_src,
           reg_dst, reg_wr, mem_to_reg, illegal, dbg_state};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rdy, input logic [19:0] exp);
    @(negedge clk);
    mem_ready = rdy;
    #1;
    chk(tag, exp);
  endtask

  task automatic fetch(input string tag, input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk);
    mem_ready = 1'b1;
    opcode    = op;
    funct     = fn;
    #1;
    chk(tag, ev(F, 1, 0, 0, 1, 1, 2'd0, 3'd0, 0, 2'd0, 0, 2'd0, 0));
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h00; alu_zero = 1'b0;
    #1;
    chk("rst_hold", z(F));
    step("rst_ready_ignored", 1'b1, z(F));
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    step("fetch_wait", 1'b0, ev(F, 1, 0, 0, 0, 0, 2'd0, 3'd0, 0, 2'd0, 0, 2'd0, 0));

    // ADD: ir_wr cycle 1, EXEC cycle 3, WB cycle 4, FETCH cycle 5
    fetch("add_f", 6'h00, 6'h20);
    step("add_dec", 1'b1, z(D));
    step("add_ex", 1'b1, z(E));
    step("add_wb", 1'b1, ev(W, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 2'd1, 1, 2'd0, 0));
    fetch("sub_f", 6'h00, 6'h22);
    step("sub_dec", 1'b1, z(D));
    step("sub_ex", 1'b1, ev(E, 0, 0, 0, 0, 0, 2'd0, 3'd1, 0, 2'd0, 0, 2'd0, 0));
    step("sub_wb", 1'b1, ev(W, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 2'd1, 1, 2'd0, 0));
    fetch("xori_f", 6'h0E, 6'h00);
    step("xori_dec", 1'b1, z(D));
    step("xori_ex", 1'b1, ev(E, 0, 0, 0, 0, 0, 2'd0, 3'd2, 1, 2'd0, 0, 2'd0, 0));
    step("xori_wb", 1'b1, ev(W, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 2'd0, 1, 2'd0, 0));

    // LW with three memory wait cycles
    fetch("lw_f", 6'h23, 6'h00);
    step("lw_dec", 1'b0, z(D));
    step("lw_ex", 1'b0, ev(E, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 0, 2'd0, 0));
    for (int i = 0; i < 4; i++)
      step($sformatf("lw_mem%0d", i), (i == 3), ev(M, 1, 0, 1, 0, 0, 2'd0, 3'd0, 0, 2'd0, 0, 2'd0, 0));
    step("lw_wb", 1'b1, ev(W, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 2'd0, 1, 2'd1, 0));

    fetch("sw_f", 6'h2B, 6'h00);
    step("sw_dec", 1'b1, z(D));
    step("sw_ex", 1'b1, ev(E, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 0, 2'd0, 0));
    step("sw_mem", 1'b1, ev(M, 1, 1, 1, 0, 0, 2'd0, 3'd0, 0, 2'd0, 0, 2'd0, 0));

    fetch("bne0_f", 6'h05, 6'h00);
    step("bne0_dec", 1'b1, z(D));
    alu_zero = 1'b0;
    step("bne0_ex", 1'b1, ev(E, 0, 0, 0, 0, 1, 2'd1, 3'd1, 0, 2'd0, 0, 2'd0, 0));
    fetch("bne1_f", 6'h05, 6'h00);
    step("bne1_dec", 1'b1, z(D));
    alu_zero = 1'b1;
    step("bne1_ex", 1'b1, ev(E, 0, 0, 0, 0, 0, 2'd1, 3'd1, 0, 2'd0, 0, 2'd0, 0));

    fetch("jal_f", 6'h03, 6'h00);
    step("jal_dec", 1'b1, ev(D, 0, 0, 0, 0, 1, 2'd2, 3'd0, 0, 2'd2, 1, 2'd2, 0));
    fetch("j_f", 6'h02, 6'h00);
    step("j_dec", 1'b1, ev(D, 0, 0, 0, 0, 1, 2'd2, 3'd0, 0, 2'd0, 0, 2'd0, 0));
    fetch("jr_f", 6'h00, 6'h08);
    step("jr_dec", 1'b1, ev(D, 0, 0, 0, 0, 1, 2'd3, 3'd0, 0, 2'd0, 0, 2'd0, 0));

    fetch("addi_f", 6'h08, 6'h00);
    step("addi_dec", 1'b1, z(D));
    step("addi_ex", 1'b1, ev(E, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 0, 2'd0, 0));
    step("addi_wb", 1'b1, ev(W, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 2'd0, 1, 2'd0, 0));
    fetch("slt_f", 6'h00, 6'h2A);
    step("slt_dec", 1'b1, z(D));
    step("slt_ex", 1'b1, ev(E, 0, 0, 0, 0, 0, 2'd0, 3'd3, 0, 2'd0, 0, 2'd0, 0));
    step("slt_wb", 1'b1, ev(W, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 2'd1, 1, 2'd0, 0));

    // reset while a load is waiting in MEM
    fetch("lw2_f", 6'h23, 6'h00);
    step("lw2_dec", 1'b0, z(D));
    step("lw2_ex", 1'b0, ev(E, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 2'd0, 0, 2'd0, 0));
    step("lw2_mem", 1'b0, ev(M, 1, 0, 1, 0, 0, 2'd0, 3'd0, 0, 2'd0, 0, 2'd0, 0));
`ifdef PERF_CNT_EN
    chk32("instr_cnt_12", instr_cnt, 32'd12);
    chk32("cyc_cnt_run", cyc_cnt, exp_cyc);
`endif
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem", z(F));
`ifdef PERF_CNT_EN
    chk32("cyc_cnt_rst", cyc_cnt, 32'd0);
    chk32("instr_cnt_rst", instr_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_fetch", 1'b0, ev(F, 1, 0, 0, 0, 0, 2'd0, 3'd0, 0, 2'd0, 0, 2'd0, 0));

    // illegal opcode: HALT absorbs, no strobes even with mem_ready high
    fetch("ill_f", 6'h3F, 6'h00);
    step("ill_dec", 1'b1, z(D));
    for (int i = 0; i < 20; i++) begin
      step($sformatf("halt%0d", i), 1'b1, ev(H, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 2'd0, 0, 2'd0, 1));
`ifdef PERF_CNT_EN
      chk32($sformatf("halt_instr%0d", i), instr_cnt, 32'd0);
      chk32($sformatf("halt_cyc%0d", i), cyc_cnt, exp_cyc);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
